lms_adapt_ctrl: RTL and testbench
=================================

Name: lms_adapt_ctrl

Overview:
Sequencing controller for the 8-tap LMS adaptive noise canceller datapath. It clears the tap delay line and weights, gates the per-sample filter and adaptation enables, and schedules the step size (coarse training, then fine tracking). It monitors a leaky average of |err| and freezes adaptation once converged. It sits between the sample-rate strobe source and the LMS datapath, and drives that datapath's clear, enable and mu inputs.

Parameters:
ERR_WIDTH, 14, width of signed err from datapath (equals DATAOUT_WIDTH)
CLR_CYCLES, 8, clocks dp_clear is held (>= filter ORDER)
TRAIN_LEN, 1024, samples spent in TRAIN
MU_SHIFT_TRAIN, 4, step-size right-shift during TRAIN (larger mu)
MU_SHIFT_TRACK, 8, step-size right-shift during TRACK (smaller mu)
AVG_SHIFT, 4, leaky-average time constant, 2^AVG_SHIFT samples
LOCK_CNT, 64, consecutive below-threshold updates required to freeze
DIVERGE_THR, 4096, err_avg level treated as divergence (optional feature)
DIVERGE_CNT, 32, consecutive updates at or above DIVERGE_THR before restart (optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin adaptation
stop  in  1  one-cycle request to abort to IDLE
sample_valid  in  1  one-cycle strobe per new signal/noise sample
err  in  ERR_WIDTH  signed error e(n) from datapath
lock_thr  in  ERR_WIDTH-1  unsigned freeze threshold on err_avg
unlock_thr  in  ERR_WIDTH-1  unsigned re-adapt threshold (unlock_thr >= lock_thr)
dp_clear  out  1  clear datapath delay line and weights
dp_en  out  1  one-cycle datapath advance strobe
adapt_en  out  1  weight-update enable
mu_shift  out  4  step-size shift to datapath
err_avg  out  ERR_WIDTH-1  leaky average of |err|
locked  out  1  high while in FREEZE
diverged  out  1  one-cycle divergence pulse
state  out  3  current state: IDLE=0, CLEAR=1, TRAIN=2, TRACK=3, FREEZE=4

Behaviour:
- All outputs are registered. On reset: state IDLE, all counters and accumulator 0, every 1-bit output 0, err_avg 0, mu_shift=MU_SHIFT_TRACK.
- IDLE: dp_en=0, adapt_en=0. start -> CLEAR. stop has priority over start; start+stop in the same cycle stays in IDLE.
- CLEAR: dp_clear=1 for exactly CLR_CYCLES clocks. Accumulator, sample counter and lock counter are zeroed. Then TRAIN.
- Sample event: sample_valid high in TRAIN/TRACK/FREEZE at cycle t:
  - dp_en=1 at t+1 for exactly one cycle.
  - adapt_en and mu_shift are registered at the same edge from the state at t, and held until the next sample event.
  - err is sampled at t.
  - sample_valid in IDLE/CLEAR is ignored.
- Averager: abs=|err|, saturated so that -2^(ERR_WIDTH-1) maps to 2^(ERR_WIDTH-1)-1. acc (ERR_WIDTH-1+AVG_SHIFT bits) <= acc - (acc>>AVG_SHIFT) + abs. err_avg = acc>>AVG_SHIFT, valid at t+1. Threshold decisions use this new err_avg, and any state change takes effect at t+2.
- TRAIN: adapt_en=1, mu=MU_SHIFT_TRAIN. On the TRAIN_LEN-th sample event the FSM moves to TRACK. That sample still uses TRAIN mu.
- TRACK: adapt_en=1, mu=MU_SHIFT_TRACK.
  - Lock counter increments on each update with err_avg < lock_thr and resets otherwise.
  - When it reaches LOCK_CNT: move to FREEZE, locked=1.
- FREEZE: adapt_en=0 while dp_en keeps pulsing. An update with err_avg > unlock_thr moves to TRACK, sets locked=0 and clears the lock counter.
- stop in any non-IDLE state -> IDLE on the next edge: dp_clear and locked drop, and no further dp_en pulses. start in a non-IDLE state is ignored.
- Sample counter saturates at TRAIN_LEN and does not wrap.

Optional Feature:
Macro LMS_DIVERGE_DET_EN.
- Defined: in TRACK or FREEZE, count consecutive updates with err_avg >= DIVERGE_THR. At DIVERGE_CNT, pulse diverged for one cycle, set locked=0 and move to CLEAR (full retrain).
- Undefined: the counter logic is absent and diverged is tied to 0.

Decomposition:
- Package lms_ctrl_pkg: state encodings, mu shift defaults, ERR_WIDTH default.
- One sub-module, lms_err_avg: abs, saturation and leaky accumulator, with clear and update-strobe inputs.

Test Plan:
1. Reset asserted mid-TRAIN (asynchronously, between edges) -> all outputs 0 and mu_shift=8 immediately; state=0.
2. start with CLR_CYCLES=8, TRAIN_LEN=16, sample_valid every 4 clocks -> dp_clear high exactly 8 clocks, then 16 dp_en pulses with mu_shift=4, then mu_shift=8 and state=3.
3. TRACK, err=0, lock_thr=10, LOCK_CNT=64 -> locked=1, state=4, adapt_en=0 after the 64th update; dp_en keeps pulsing.
4. FREEZE with acc=0, err steps to +2000, unlock_thr=100 -> err_avg=125 after the first sample; state=3 and locked=0 two cycles after that sample_valid.
5. err=-8192 (ERR_WIDTH=14), one update from 0 -> acc=8191, err_avg=511.
6. start and stop in the same IDLE cycle -> stays IDLE. With LMS_DIVERGE_DET_EN, err=+8191 held in TRACK -> diverged pulses once, state=1.

Source files
------------

// File: rtl/lms_ctrl_pkg.sv
// rtl/lms_ctrl_pkg.sv - state encodings and default widths/step sizes for the LMS adaptation controller
package lms_ctrl_pkg;

    localparam int ERR_WIDTH_DEF      = 14;
    localparam int MU_SHIFT_TRAIN_DEF = 4;
    localparam int MU_SHIFT_TRACK_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_TRAIN  = 3'd2,
        ST_TRACK  = 3'd3,
        ST_FREEZE = 3'd4
    } lms_state_t;

    // States in which sample strobes advance the datapath
    function automatic logic is_active(input lms_state_t s);
        return (s == ST_TRAIN) || (s == ST_TRACK) || (s == ST_FREEZE);
    endfunction

endpackage

// File: rtl/lms_err_avg.sv
// rtl/lms_err_avg.sv - saturating |err| and leaky average with 2^AVG_SHIFT sample time constant
module lms_err_avg
    import lms_ctrl_pkg::*;
#(
    parameter int ERR_WIDTH = ERR_WIDTH_DEF,
    parameter int AVG_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 upd,
    input  logic [ERR_WIDTH-1:0] err,
    output logic [ERR_WIDTH-2:0] err_avg
);

    localparam int AW   = ERR_WIDTH - 1;
    localparam int ACCW = AW + AVG_SHIFT;

    logic [ERR_WIDTH-1:0] neg_err;
    logic [AW-1:0]        abs_err;
    logic [ACCW-1:0]      acc;
    logic [ACCW-1:0]      acc_nxt;

    assign neg_err = -err;

    // Only the most negative code negates back to a set sign bit; clamp it to full scale
    always_comb begin
        abs_err = err[AW-1:0];
        if (err[ERR_WIDTH-1]) begin
            abs_err = neg_err[ERR_WIDTH-1] ? {AW{1'b1}} : neg_err[AW-1:0];
        end
    end

    assign acc_nxt = acc - (acc >> AVG_SHIFT) + {{AVG_SHIFT{1'b0}}, abs_err};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (upd) begin
            acc <= acc_nxt;
        end
    end

    assign err_avg = acc[ACCW-1:AVG_SHIFT];

endmodule

// File: rtl/lms_adapt_ctrl.sv
// rtl/lms_adapt_ctrl.sv - LMS canceller sequencer: clear, train, track, freeze; divergence restart under LMS_DIVERGE_DET_EN
module lms_adapt_ctrl
    import lms_ctrl_pkg::*;
#(
    parameter int ERR_WIDTH      = ERR_WIDTH_DEF,
    parameter int CLR_CYCLES     = 8,
    parameter int TRAIN_LEN      = 1024,
    parameter int MU_SHIFT_TRAIN = MU_SHIFT_TRAIN_DEF,
    parameter int MU_SHIFT_TRACK = MU_SHIFT_TRACK_DEF,
    parameter int AVG_SHIFT      = 4,
    parameter int LOCK_CNT       = 64,
    parameter int DIVERGE_THR    = 4096,
    parameter int DIVERGE_CNT    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 sample_valid,
    input  logic [ERR_WIDTH-1:0] err,
    input  logic [ERR_WIDTH-2:0] lock_thr,
    input  logic [ERR_WIDTH-2:0] unlock_thr,
    output logic                 dp_clear,
    output logic                 dp_en,
    output logic                 adapt_en,
    output logic [3:0]           mu_shift,
    output logic [ERR_WIDTH-2:0] err_avg,
    output logic                 locked,
    output logic                 diverged,
    output logic [2:0]           state
);

    localparam int AW = ERR_WIDTH - 1;
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam int SW = $clog2(TRAIN_LEN + 1);
    localparam int LW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] CLR_LAST    = CW'(CLR_CYCLES - 1);
    localparam logic [SW-1:0] TRAIN_LEN_C = SW'(TRAIN_LEN);
    localparam logic [LW-1:0] LOCK_CNT_C  = LW'(LOCK_CNT);
    localparam logic [3:0]    MU_TRAIN_C  = 4'(MU_SHIFT_TRAIN);
    localparam logic [3:0]    MU_TRACK_C  = 4'(MU_SHIFT_TRACK);

    lms_state_t    state_q, state_nxt;
    logic [CW-1:0] clr_cnt, clr_cnt_nxt;
    logic [SW-1:0] smp_cnt, smp_cnt_nxt;
    logic [LW-1:0] lock_cnt, lock_cnt_nxt;
    logic          dp_clear_nxt, dp_en_nxt, adapt_en_nxt, locked_nxt;
    logic [3:0]    mu_nxt;
    logic          avg_clr, avg_upd;

`ifdef LMS_DIVERGE_DET_EN
    localparam int            DW          = $clog2(DIVERGE_CNT + 1);
    localparam logic [DW-1:0] DIV_CNT_C   = DW'(DIVERGE_CNT);
    localparam logic [AW-1:0] DIV_THR_C   = AW'(DIVERGE_THR);
    logic [DW-1:0] div_cnt, div_cnt_nxt;
    logic          diverged_q, diverged_nxt;
`endif

    assign state   = state_q;
    assign avg_clr = (state_q == ST_CLEAR);
    assign avg_upd = sample_valid && is_active(state_q) && !stop;

    lms_err_avg #(
        .ERR_WIDTH (ERR_WIDTH),
        .AVG_SHIFT (AVG_SHIFT)
    ) u_err_avg (
        .clk     (clk),
        .rst     (rst),
        .clr     (avg_clr),
        .upd     (avg_upd),
        .err     (err),
        .err_avg (err_avg)
    );

    // dp_en doubles as the "err_avg was just refreshed" marker, so threshold decisions land one clock after it
    always_comb begin
        state_nxt    = state_q;
        clr_cnt_nxt  = clr_cnt;
        smp_cnt_nxt  = smp_cnt;
        lock_cnt_nxt = lock_cnt;
        dp_clear_nxt = 1'b0;
        dp_en_nxt    = 1'b0;
        adapt_en_nxt = adapt_en;
        mu_nxt       = mu_shift;
        locked_nxt   = locked;
`ifdef LMS_DIVERGE_DET_EN
        div_cnt_nxt  = div_cnt;
        diverged_nxt = 1'b0;
`endif
        if (stop && state_q != ST_IDLE) begin
            state_nxt    = ST_IDLE;
            adapt_en_nxt = 1'b0;
            locked_nxt   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    adapt_en_nxt = 1'b0;
                    if (start && !stop) begin
                        state_nxt    = ST_CLEAR;
                        dp_clear_nxt = 1'b1;
                        clr_cnt_nxt  = '0;
                    end
                end
                ST_CLEAR: begin
                    dp_clear_nxt = 1'b1;
                    clr_cnt_nxt  = clr_cnt + 1'b1;
                    smp_cnt_nxt  = '0;
                    lock_cnt_nxt = '0;
                    adapt_en_nxt = 1'b0;
                    locked_nxt   = 1'b0;
`ifdef LMS_DIVERGE_DET_EN
                    div_cnt_nxt  = '0;
`endif
                    if (clr_cnt == CLR_LAST) begin
                        state_nxt    = ST_TRAIN;
                        dp_clear_nxt = 1'b0;
                    end
                end
                default: begin
                    if (sample_valid) begin
                        dp_en_nxt    = 1'b1;
                        adapt_en_nxt = (state_q != ST_FREEZE);
                        mu_nxt       = (state_q == ST_TRAIN) ? MU_TRAIN_C : MU_TRACK_C;
                        if (smp_cnt != TRAIN_LEN_C) begin
                            smp_cnt_nxt = smp_cnt + 1'b1;
                        end
                    end
                    if (dp_en) begin
                        if (state_q == ST_TRAIN) begin
                            if (smp_cnt == TRAIN_LEN_C) begin
                                state_nxt = ST_TRACK;
                            end
                        end else if (state_q == ST_TRACK) begin
                            if (err_avg < lock_thr) begin
                                lock_cnt_nxt = lock_cnt + 1'b1;
                                if (lock_cnt_nxt == LOCK_CNT_C) begin
                                    state_nxt  = ST_FREEZE;
                                    locked_nxt = 1'b1;
                                end
                            end else begin
                                lock_cnt_nxt = '0;
                            end
                        end else if (err_avg > unlock_thr) begin
                            state_nxt    = ST_TRACK;
                            locked_nxt   = 1'b0;
                            lock_cnt_nxt = '0;
                        end
`ifdef LMS_DIVERGE_DET_EN
                        if (state_q != ST_TRAIN) begin
                            div_cnt_nxt = (err_avg >= DIV_THR_C) ? div_cnt + 1'b1 : '0;
                            if (div_cnt_nxt == DIV_CNT_C) begin
                                state_nxt    = ST_CLEAR;
                                dp_clear_nxt = 1'b1;
                                clr_cnt_nxt  = '0;
                                locked_nxt   = 1'b0;
                                diverged_nxt = 1'b1;
                            end
                        end
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            clr_cnt  <= '0;
            smp_cnt  <= '0;
            lock_cnt <= '0;
            dp_clear <= 1'b0;
            dp_en    <= 1'b0;
            adapt_en <= 1'b0;
            mu_shift <= MU_TRACK_C;
            locked   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            smp_cnt  <= smp_cnt_nxt;
            lock_cnt <= lock_cnt_nxt;
            dp_clear <= dp_clear_nxt;
            dp_en    <= dp_en_nxt;
            adapt_en <= adapt_en_nxt;
            mu_shift <= mu_nxt;
            locked   <= locked_nxt;
        end
    end

`ifdef LMS_DIVERGE_DET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            diverged_q <= 1'b0;
        end else begin
            div_cnt    <= div_cnt_nxt;
            diverged_q <= diverged_nxt;
        end
    end

    assign diverged = diverged_q;
`else
    logic unused_div_cfg;
    assign unused_div_cfg = (DIVERGE_THR > 0) && (DIVERGE_CNT > 0);
    assign diverged       = 1'b0;
`endif

endmodule

// File: tb/tb_lms_adapt_ctrl.sv
// tb/tb_lms_adapt_ctrl.sv - self-checking bench for lms_adapt_ctrl with a per-sample transaction model
module tb_lms_adapt_ctrl;

    localparam int EW         = 14;
    localparam int CLR        = 8;
    localparam int TLEN       = 16;
    localparam int LOCK       = 64;
    localparam int LOCK_THR   = 10;
    localparam int UNLOCK_THR = 100;
    localparam int S_IDLE = 0, S_CLEAR = 1, S_TRAIN = 2, S_TRACK = 3, S_FREEZE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, sample_valid;
    logic [EW-1:0] err;
    logic [EW-2:0] lock_thr, unlock_thr;
    logic          dp_clear, dp_en, adapt_en, locked, diverged;
    logic [3:0]    mu_shift;
    logic [EW-2:0] err_avg;
    logic [2:0]    state;

    lms_adapt_ctrl #(
        .ERR_WIDTH  (EW),
        .CLR_CYCLES (CLR),
        .TRAIN_LEN  (TLEN),
        .LOCK_CNT   (LOCK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .sample_valid (sample_valid),
        .err          (err),
        .lock_thr     (lock_thr),
        .unlock_thr   (unlock_thr),
        .dp_clear     (dp_clear),
        .dp_en        (dp_en),
        .adapt_en     (adapt_en),
        .mu_shift     (mu_shift),
        .err_avg      (err_avg),
        .locked       (locked),
        .diverged     (diverged),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int adapt;
        int mu;
        int avg;
        int st;
        int lk;
        int dv;
    } exp_t;

    exp_t q[$];
    exp_t pend_x;
    bit   pend;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   div_pulses = 0;
    int   m_mode, m_acc, m_samples, m_lock, m_div;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_dp_clear"}, int'(dp_clear), 0);
        chk({tag, "_dp_en"},    int'(dp_en),    0);
        chk({tag, "_adapt_en"}, int'(adapt_en), 0);
        chk({tag, "_mu"},       int'(mu_shift), 8);
        chk({tag, "_err_avg"},  int'(err_avg),  0);
        chk({tag, "_locked"},   int'(locked),   0);
        chk({tag, "_diverged"}, int'(diverged), 0);
        chk({tag, "_state"},    int'(state),    S_IDLE);
    endtask

    // Model: one sample updates the leaky average, then the rules decide the mode that follows it
    task automatic do_sample(input int e);
        exp_t x;
        int   a, mode0;
        mode0 = m_mode;
        a = (e < 0) ? -e : e;
        if (a > 8191) a = 8191;
        m_acc   = m_acc - (m_acc / 16) + a;
        x.adapt = (mode0 != S_FREEZE) ? 1 : 0;
        x.mu    = (mode0 == S_TRAIN) ? 4 : 8;
        x.avg   = m_acc / 16;
        x.dv    = 0;
        if (m_samples < TLEN) m_samples++;
        if (mode0 == S_TRAIN) begin
            if (m_samples == TLEN) m_mode = S_TRACK;
        end else if (mode0 == S_TRACK) begin
            m_lock = (x.avg < LOCK_THR) ? m_lock + 1 : 0;
            if (m_lock == LOCK) m_mode = S_FREEZE;
        end else if (mode0 == S_FREEZE && x.avg > UNLOCK_THR) begin
            m_mode = S_TRACK;
            m_lock = 0;
        end
`ifdef LMS_DIVERGE_DET_EN
        if (mode0 == S_TRACK || mode0 == S_FREEZE) begin
            m_div = (x.avg >= 4096) ? m_div + 1 : 0;
            if (m_div == 32) begin
                m_mode = S_CLEAR;
                x.dv   = 1;
            end
        end
`endif
        x.st = m_mode;
        x.lk = (m_mode == S_FREEZE) ? 1 : 0;
        q.push_back(x);
        @(negedge clk);
        sample_valid = 1'b1;
        err          = EW'(e);
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_start();
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clear_state", int'(state), S_CLEAR);
        n = 0;
        while (dp_clear && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("clear_len", n, CLR);
        chk("clear_then_train", int'(state), S_TRAIN);
        m_mode = S_TRAIN;
        m_acc = 0; m_samples = 0; m_lock = 0; m_div = 0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
        end else begin
            if (diverged) div_pulses++;
            if (pend) begin
                chk("dp_en_width", int'(dp_en),    0);
                chk("state_after", int'(state),    pend_x.st);
                chk("locked_after", int'(locked),  pend_x.lk);
                chk("diverged_after", int'(diverged), pend_x.dv);
                pend = 0;
            end else if (dp_en) begin
                if (q.size() == 0) begin
                    chk("spurious_dp_en", 1, 0);
                end else begin
                    pend_x = q.pop_front();
                    chk("adapt_en", int'(adapt_en), pend_x.adapt);
                    chk("mu_shift", int'(mu_shift), pend_x.mu);
                    chk("err_avg",  int'(err_avg),  pend_x.avg);
                    pend = 1;
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; sample_valid = 1'b0; err = '0;
        lock_thr = EW'(LOCK_THR) & {(EW-1){1'b1}};
        unlock_thr = EW'(UNLOCK_THR) & {(EW-1){1'b1}};
        m_mode = S_IDLE; m_acc = 0; m_samples = 0; m_lock = 0; m_div = 0;
        repeat (3) @(negedge clk);
        chk_rst("reset");
        rst = 1'b0;

        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_state", int'(state), S_IDLE);
        chk("start_stop_clear", int'(dp_clear), 0);

        do_start();
        do_sample(-8192);
        chk("avg_min_err", int'(err_avg), 511);
        do_sample(0);
        chk("avg_decay", int'(err_avg), 480);

        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_rst("async_rst");
        q.delete();
        m_mode = S_IDLE;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_start();
        for (int i = 0; i < TLEN; i++) do_sample(0);
        chk("train_done_state", int'(state), S_TRACK);
        chk("last_train_mu", int'(mu_shift), 4);

        n = 0;
        while (!locked && n < 100) begin
            do_sample(0);
            n++;
            if (n == 1) chk("first_track_mu", int'(mu_shift), 8);
        end
        chk("lock_updates", n, LOCK);
        chk("freeze_state", int'(state), S_FREEZE);

        do_sample(0);
        chk("freeze_adapt", int'(adapt_en), 0);
        chk("freeze_locked", int'(locked), 1);
        do_sample(2000);
        chk("unlock_avg", int'(err_avg), 125);
        chk("unlock_state", int'(state), S_TRACK);
        chk("unlock_locked", int'(locked), 0);

`ifdef LMS_DIVERGE_DET_EN
        for (int i = 0; i < 80 && m_mode != S_CLEAR; i++) do_sample(8191);
        chk("diverge_state", int'(state), S_CLEAR);
        chk("diverge_pulses", div_pulses, 1);
`else
        repeat (60) do_sample(8191);
        chk("no_diverge_state", int'(state), S_TRACK);
        chk("no_diverge_pulses", div_pulses, 0);
`endif

        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_state", int'(state), S_IDLE);
        chk("stop_clear", int'(dp_clear), 0);
        chk("stop_locked", int'(locked), 0);

        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("idle_sample_ignored", int'(dp_en), 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
